// File: rtl/wishbone_ram_target.sv
// wishbone_ram_target: pipelined Wishbone B4 target backed by on-chip RAM with programmable wait states
module wishbone_ram_target #(
  parameter int AddressWidth = 16,
  parameter int DataWidth = 32,
  parameter int Granularity = 8,
  parameter int TGDWidth = 1,
  parameter int Depth = 256,
  parameter int WaitStates = 0,
  parameter bit LOWPOWER = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cyc,
  input  logic                               stb,
  input  logic                               we,
  input  logic                               lock,
  input  logic [AddressWidth-1:0]            addr,
  input  logic [DataWidth/Granularity-1:0]   sel,
  input  logic [DataWidth-1:0]               dat_to_target,
  input  logic [TGDWidth-1:0]                tgd_to_target,
  output logic [DataWidth-1:0]               dat_to_initiator,
  output logic [TGDWidth-1:0]                tgd_to_initiator,
  output logic                               ack,
  output logic                               err,
  output logic                               rty,
  output logic                               stall
);
  localparam int SW = DataWidth / Granularity;
  localparam int LS = $clog2(SW);
  localparam int IW = Depth > 1 ? $clog2(Depth) : 1;
  localparam logic [AddressWidth:0] DEPTH_W = (AddressWidth + 1)'(Depth);
  logic [DataWidth-1:0] mem [Depth];
  logic pending_q, pending_d, stall_q, stall_d, we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic [3:0] waitcnt_q, waitcnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [AddressWidth-1:0] idx_q, idx_d;
  logic [DataWidth-1:0] wdat_q, wdat_d, rdat_q, rdat_d, mem_rd;
  logic [TGDWidth-1:0] tag_q, tag_d, rtgd_q, rtgd_d;
  logic accept, resp, oor, unused_lock;
  assign unused_lock = lock;
  always_comb begin
    accept = cyc & stb & !stall_q;
    resp = pending_q & cyc & (waitcnt_q == 4'd0);
    oor = {1'b0, idx_q} >= DEPTH_W;
    mem_rd = mem[idx_q[IW-1:0]];
    pending_d = accept | (pending_q & cyc & !resp);
    waitcnt_d = accept ? 4'(WaitStates) : (cyc && waitcnt_q != 4'd0) ? waitcnt_q - 4'd1 : 4'd0;
    stall_d = accept ? (WaitStates != 0) : (cyc & pending_q & (waitcnt_q > 4'd1));
    we_d = accept ? we : we_q;
    sel_d = accept ? sel : sel_q;
    idx_d = accept ? addr >> LS : idx_q;
    wdat_d = accept ? dat_to_target : wdat_q;
    tag_d = accept ? tgd_to_target : tag_q;
    ack_d = resp & !oor;
    err_d = resp & oor;
    rdat_d = (resp & !oor & !we_q) ? mem_rd : ((resp & oor) | LOWPOWER) ? '0 : rdat_q;
    rtgd_d = resp ? tag_q : LOWPOWER ? '0 : rtgd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      waitcnt_q <= 4'd0;
      stall_q <= 1'b0;
      we_q <= 1'b0;
      sel_q <= '0;
      idx_q <= '0;
      wdat_q <= '0;
      tag_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rdat_q <= '0;
      rtgd_q <= '0;
    end else begin
      pending_q <= pending_d;
      waitcnt_q <= waitcnt_d;
      stall_q <= stall_d;
      we_q <= we_d;
      sel_q <= sel_d;
      idx_q <= idx_d;
      wdat_q <= wdat_d;
      tag_q <= tag_d;
      ack_q <= ack_d;
      err_q <= err_d;
      rdat_q <= rdat_d;
      rtgd_q <= rtgd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && resp && we_q && !oor)
      for (int i = 0; i < SW; i++)
        if (sel_q[i]) mem[idx_q[IW-1:0]][i*Granularity +: Granularity] <= wdat_q[i*Granularity +: Granularity];
  end
  assign dat_to_initiator = rdat_q;
  assign tgd_to_initiator = rtgd_q;
  assign ack = ack_q;
  assign err = err_q;
  assign rty = 1'b0;
  assign stall = stall_q;
endmodule
